id_stage_param: RTL and testbench

- Parametrised decode stage for the pipelined MIPS core. Contains the IF/ID pipeline register (stall, flush, valid bit), a general-purpose register file with write-through bypass, N-source operand forwarding, a branch comparator and next-PC generation.
- Sits between fetch and execute. Generalises the fixed 32-bit decode stage with configurable data width, register count, forwarding-source count and explicit bubble/flush support.

---
 rtl/id_pkg.sv | 41 ++++
 rtl/gp_regfile.sv | 52 +++++
 rtl/id_stage_param.sv | 181 ++++++++++++++++++
 tb/tb_id_stage_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared encodings and instruction field positions for the decode stage.
package id_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'd0,
        EXT_SIGN  = 2'd1,
        EXT_LUI   = 2'd2,
        EXT_ZERO3 = 2'd3
    } ext_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5,
        BR_RSV6 = 3'd6,
        BR_RSV7 = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        JM_SEQ    = 2'd0,
        JM_BRANCH = 2'd1,
        JM_J      = 2'd2,
        JM_JR     = 2'd3
    } jump_mode_e;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned INDEX_HI = 25;
    localparam int unsigned INDEX_LO = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/gp_regfile.sv
// General-purpose register file: hardwired zero register, two combinational
// read ports with write-through bypass, one synchronous write port.
module gp_regfile
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr_a,
    input  logic [AW-1:0]   i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_regs <= '{default: '0};
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if (w_wr_en && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
        if (w_wr_en && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
        if (i_raddr_a == '0) begin
            o_rdata_a = '0;
        end
        if (i_raddr_b == '0) begin
            o_rdata_b = '0;
        end
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised MIPS decode stage: IF/ID register, register file, operand
// forwarding, branch comparator and next-PC generation.
module id_stage_param
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NFWD = 2,
    localparam int unsigned AW  = $clog2(NREG),
    localparam int unsigned SW  = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          if_instr,
    input  logic [XLEN-1:0]      if_pc,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [SW-1:0]        fwd_sel_a,
    input  logic [SW-1:0]        fwd_sel_b,
    input  logic [1:0]           ext_op,
    input  logic [2:0]           br_op,
    input  logic [1:0]           jump_mode,
    output logic [31:0]          id_instr,
    output logic [XLEN-1:0]      id_pc,
    output logic [XLEN-1:0]      id_pc4,
    output logic                 id_valid,
    output logic [XLEN-1:0]      rs_val,
    output logic [XLEN-1:0]      rt_val,
    output logic [XLEN-1:0]      imm_ext,
    output logic                 taken,
    output logic                 redirect,
    output logic [XLEN-1:0]      npc
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    logic [RS_HI-RS_LO:0]       w_rs_field;
    logic [RT_HI-RT_LO:0]       w_rt_field;
    logic [IMM_HI-IMM_LO:0]     w_imm;
    logic [INDEX_HI-INDEX_LO:0] w_index;
    logic [XLEN-1:0]            w_rf_rs;
    logic [XLEN-1:0]            w_rf_rt;
    logic [XLEN-1:0]            w_rs_val;
    logic [XLEN-1:0]            w_rt_val;
    logic [XLEN-1:0]            w_pc4;
    logic [XLEN-1:0]            w_pc8;
    logic [XLEN-1:0]            w_br_off;
    logic [XLEN-1:0]            w_target;
    logic                       w_taken;
    logic                       w_redirect;
    logic                       w_rs_neg;
    logic                       w_rs_zero;

    // IF/ID register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= if_instr;
            r_pc    <= if_pc;
            r_valid <= 1'b1;
        end
    end

    assign w_rs_field = r_instr[RS_HI:RS_LO];
    assign w_rt_field = r_instr[RT_HI:RT_LO];
    assign w_imm      = r_instr[IMM_HI:IMM_LO];
    assign w_index    = r_instr[INDEX_HI:INDEX_LO];

    gp_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs_field[AW-1:0]),
        .i_raddr_b (w_rt_field[AW-1:0]),
        .o_rdata_a (w_rf_rs),
        .o_rdata_b (w_rf_rt)
    );

    // Select k picks slot k-1; zero or anything beyond NFWD keeps the regfile value.
    always_comb begin
        w_rs_val = w_rf_rs;
        w_rt_val = w_rf_rt;
        for (int k = 1; k <= NFWD; k++) begin
            if (fwd_sel_a == SW'(k)) begin
                w_rs_val = fwd_data[(k-1)*XLEN +: XLEN];
            end
            if (fwd_sel_b == SW'(k)) begin
                w_rt_val = fwd_data[(k-1)*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        imm_ext = {{(XLEN-16){1'b0}}, w_imm};
        case (ext_op_e'(ext_op))
            EXT_ZERO:  imm_ext = {{(XLEN-16){1'b0}}, w_imm};
            EXT_SIGN:  imm_ext = {{(XLEN-16){w_imm[15]}}, w_imm};
            EXT_LUI:   imm_ext = XLEN'({w_imm, 16'h0000});
            EXT_ZERO3: imm_ext = {{(XLEN-16){1'b0}}, w_imm};
            default:   imm_ext = {{(XLEN-16){1'b0}}, w_imm};
        endcase
    end

    assign w_rs_neg  = w_rs_val[XLEN-1];
    assign w_rs_zero = (w_rs_val == '0);

    always_comb begin
        w_taken = 1'b0;
        case (br_op_e'(br_op))
            BR_EQ:   w_taken = (w_rs_val == w_rt_val);
            BR_NE:   w_taken = (w_rs_val != w_rt_val);
            BR_LEZ:  w_taken = w_rs_neg || w_rs_zero;
            BR_GTZ:  w_taken = !w_rs_neg && !w_rs_zero;
            BR_LTZ:  w_taken = w_rs_neg;
            BR_GEZ:  w_taken = !w_rs_neg;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc4    = r_pc + XLEN'(4);
    assign w_pc8    = r_pc + XLEN'(8);
    assign w_br_off = {{(XLEN-18){w_imm[15]}}, w_imm, 2'b00};

    // Target selection; fall-through skips the delay slot.
    always_comb begin
        w_target   = w_pc8;
        w_redirect = 1'b0;
        case (jump_mode_e'(jump_mode))
            JM_SEQ: begin
                w_target   = w_pc8;
                w_redirect = 1'b0;
            end
            JM_BRANCH: begin
                w_target   = w_pc4 + w_br_off;
                w_redirect = w_taken;
            end
            JM_J: begin
                w_target   = {w_pc4[XLEN-1:28], w_index, 2'b00};
                w_redirect = 1'b1;
            end
            JM_JR: begin
                w_target   = w_rs_val;
                w_redirect = 1'b1;
            end
            default: begin
                w_target   = w_pc8;
                w_redirect = 1'b0;
            end
        endcase
        w_redirect = w_redirect && r_valid;
    end

    assign id_instr = r_instr;
    assign id_pc    = r_pc;
    assign id_pc4   = w_pc4;
    assign id_valid = r_valid;
    assign rs_val   = w_rs_val;
    assign rt_val   = w_rt_val;
    assign taken    = w_taken;
    assign redirect = w_redirect;
    assign npc      = w_redirect ? w_target : w_pc8;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param with a tag-keyed expectation scoreboard.
module tb_id_stage_param;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NFWD = 2;
    localparam int unsigned AW   = 5;
    localparam int unsigned SW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          if_instr;
    logic [XLEN-1:0]      if_pc;
    logic                 stall, flush, wb_we;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [SW-1:0]        fwd_sel_a, fwd_sel_b;
    logic [1:0]           ext_op;
    logic [2:0]           br_op;
    logic [1:0]           jump_mode;
    logic [31:0]          id_instr;
    logic [XLEN-1:0]      id_pc, id_pc4, rs_val, rt_val, imm_ext, npc;
    logic                 id_valid, taken, redirect;

    always #5 clk = ~clk;

    id_stage_param #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b), .ext_op(ext_op), .br_op(br_op),
        .jump_mode(jump_mode), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc4(id_pc4), .id_valid(id_valid), .rs_val(rs_val),
        .rt_val(rt_val), .imm_ext(imm_ext), .taken(taken),
        .redirect(redirect), .npc(npc)
    );

    typedef struct {
        string           tag;
        logic [XLEN-1:0] exp;
    } sb_t;

    sb_t   sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string step  = "init";

    task automatic push(input string tag, input logic [XLEN-1:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sb.push_back(s);
    endtask

    function automatic logic [XLEN-1:0] obs_of(input string tag);
        if (tag == "id_instr") return id_instr;
        if (tag == "id_pc")    return id_pc;
        if (tag == "id_pc4")   return id_pc4;
        if (tag == "id_valid") return XLEN'(id_valid);
        if (tag == "rs_val")   return rs_val;
        if (tag == "rt_val")   return rt_val;
        if (tag == "imm_ext")  return imm_ext;
        if (tag == "taken")    return XLEN'(taken);
        if (tag == "redirect") return XLEN'(redirect);
        if (tag == "npc")      return npc;
        return 'x;
    endfunction

    // Let combinational outputs settle, then drain every pending expectation.
    task automatic check_all();
        sb_t             s;
        logic [XLEN-1:0] o;
        #2;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            o = obs_of(s.tag);
            n_cmp++;
            assert (o === s.exp) else begin
                n_err++;
                $error("FAIL %s/%s: observed %h expected %h", step, s.tag, o, s.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        fwd_data = '0; fwd_sel_a = '0; fwd_sel_b = '0;
        ext_op = 2'd0; br_op = 3'd7; jump_mode = 2'd0;
        if_instr = 32'h1000_0003; if_pc = 32'h3000;

        tick(); tick();
        step = "reset";
        push("id_valid", 0); push("id_instr", 0); push("id_pc", 0);
        push("redirect", 0); push("npc", 32'h8); push("rs_val", 0);
        check_all();

        reset = 1'b1;
        tick();
        ext_op = 2'd1;
        step = "load";
        push("id_pc", 32'h3000); push("id_pc4", 32'h3004); push("id_valid", 1);
        push("id_instr", 32'h1000_0003); push("npc", 32'h3008);
        push("redirect", 0); push("imm_ext", 32'h3);
        check_all();

        // Stall for four cycles while register writes land underneath.
        stall = 1'b1; if_instr = 32'hFFFF_FFFF; if_pc = 32'h4000;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h7;
        tick();
        step = "stall1";
        push("id_pc", 32'h3000); push("id_instr", 32'h1000_0003); push("id_valid", 1);
        check_all();
        wb_addr = 5'd5; wb_data = 32'h11;
        tick();
        step = "stall2";
        push("id_pc", 32'h3000); push("id_valid", 1);
        check_all();
        wb_addr = 5'd9; wb_data = 32'h8000_0000;
        tick();
        step = "stall3";
        push("id_pc", 32'h3000); push("id_instr", 32'h1000_0003);
        check_all();
        wb_addr = 5'd3; wb_data = 32'h3400;
        tick();
        wb_we = 1'b0;
        step = "stall4";
        push("id_pc", 32'h3000); push("id_valid", 1);
        check_all();

        flush = 1'b1;
        tick();
        step = "stall_flush";
        push("id_instr", 0); push("id_valid", 0); push("id_pc", 0);
        check_all();
        flush = 1'b0; stall = 1'b0;

        if_instr = 32'h00A0_0000; if_pc = 32'h3100;
        tick();
        step = "rs5_reg";
        push("rs_val", 32'h11); push("rt_val", 0); push("id_pc", 32'h3100);
        push("id_valid", 1);
        check_all();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        step = "bypass";
        push("rs_val", 32'hDEAD_BEEF);
        check_all();
        tick();
        wb_we = 1'b0;
        step = "after_write";
        push("rs_val", 32'hDEAD_BEEF);
        check_all();

        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        step = "r0_bypass";
        push("rt_val", 0);
        check_all();
        tick();
        wb_we = 1'b0;
        step = "r0_after";
        push("rt_val", 0); push("rs_val", 32'hDEAD_BEEF);
        check_all();

        fwd_data = {32'h55, 32'h66};
        fwd_sel_a = 2'd2;
        step = "fwd_a2";
        push("rs_val", 32'h55);
        check_all();
        tick();
        fwd_sel_a = 2'd1; fwd_sel_b = 2'd1;
        step = "fwd_a1_b1";
        push("rs_val", 32'h66); push("rt_val", 32'h66);
        check_all();
        tick();
        fwd_sel_a = 2'd3; fwd_sel_b = 2'd2;
        step = "fwd_out_of_range";
        push("rs_val", 32'hDEAD_BEEF); push("rt_val", 32'h55);
        check_all();
        fwd_sel_a = '0; fwd_sel_b = '0;

        // beq $7,$7,-1 at 0x3010 branches back onto itself.
        if_instr = 32'h10E7_FFFF; if_pc = 32'h3010;
        tick();
        jump_mode = 2'd1; br_op = 3'd0; ext_op = 2'd1;
        step = "beq";
        push("rs_val", 32'h7); push("rt_val", 32'h7); push("taken", 1);
        push("redirect", 1); push("npc", 32'h3010); push("imm_ext", 32'hFFFF_FFFF);
        check_all();
        tick();
        br_op = 3'd1; ext_op = 2'd0;
        step = "bne";
        push("taken", 0); push("redirect", 0); push("npc", 32'h3018);
        push("imm_ext", 32'h0000_FFFF);
        check_all();
        tick();
        br_op = 3'd0; ext_op = 2'd2; fwd_sel_b = 2'd1;
        step = "beq_fwd_ne";
        push("taken", 0); push("npc", 32'h3018); push("imm_ext", 32'hFFFF_0000);
        check_all();
        tick();
        ext_op = 2'd3; fwd_sel_b = '0;
        step = "ext3";
        push("imm_ext", 32'h0000_FFFF); push("taken", 1);
        check_all();

        // Sign tests on rs = $9 = 0x8000_0000, offset +4 words.
        if_instr = 32'h1D20_0004; if_pc = 32'h3010; br_op = 3'd3;
        tick();
        step = "bgtz_neg";
        push("rs_val", 32'h8000_0000); push("taken", 0); push("redirect", 0);
        push("npc", 32'h3018);
        check_all();
        tick();
        br_op = 3'd4;
        step = "bltz_neg";
        push("taken", 1); push("redirect", 1); push("npc", 32'h3024);
        check_all();
        tick();
        br_op = 3'd2;
        step = "blez_neg";
        push("taken", 1);
        check_all();
        tick();
        br_op = 3'd5;
        step = "bgez_neg";
        push("taken", 0); push("npc", 32'h3018);
        check_all();
        tick();
        fwd_data = {32'h55, 32'h0}; fwd_sel_a = 2'd1;
        step = "bgez_zero";
        push("taken", 1);
        check_all();
        tick();
        br_op = 3'd3;
        step = "bgtz_zero";
        push("taken", 0);
        check_all();
        tick();
        br_op = 3'd2;
        step = "blez_zero";
        push("taken", 1);
        check_all();
        tick();
        fwd_data = {32'h55, 32'h1}; br_op = 3'd3;
        step = "bgtz_pos";
        push("taken", 1); push("npc", 32'h3024);
        check_all();
        tick();
        br_op = 3'd6;
        step = "br_undef";
        push("taken", 0); push("redirect", 0);
        check_all();
        fwd_sel_a = '0;

        if_instr = 32'h0800_0C04; if_pc = 32'h3000; jump_mode = 2'd2; br_op = 3'd7;
        tick();
        step = "j";
        push("redirect", 1); push("npc", 32'h3010);
        check_all();
        if_pc = 32'hF000_0000;
        tick();
        step = "j_region";
        push("redirect", 1); push("npc", 32'hF000_3010);
        check_all();

        if_instr = 32'h0060_0008; if_pc = 32'h3200; jump_mode = 2'd3;
        tick();
        step = "jr";
        push("rs_val", 32'h3400); push("redirect", 1); push("npc", 32'h3400);
        check_all();
        tick();
        fwd_data = {32'h5000, 32'h1}; fwd_sel_a = 2'd2;
        step = "jr_fwd";
        push("npc", 32'h5000);
        check_all();
        fwd_sel_a = '0;

        flush = 1'b1; jump_mode = 2'd2;
        tick();
        step = "bubble_j";
        push("id_valid", 0); push("redirect", 0); push("npc", 32'h8);
        check_all();
        tick();
        jump_mode = 2'd3;
        step = "bubble_jr";
        push("redirect", 0); push("npc", 32'h8);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
